// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encodings and counter sizing for debounce_sync
package debounce_pkg;

  // 2-bit FSM state encodings
  localparam logic [1:0] ST_IDLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_IDLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  // Default qualification counter width; 2**DEF_CNT_W must cover STABLE_CYCLES
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE_LO = ST_IDLE_LO,
    WAIT_HI = ST_WAIT_HI,
    IDLE_HI = ST_IDLE_HI,
    WAIT_LO = ST_WAIT_LO
  } state_t;

endpackage

// File: rtl/sync_nff.sv
// rtl/sync_nff.sv - N-flop synchroniser for a single asynchronous level
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the chain; the last flop is the clean sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw level with rise/fall pulses
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             q_nx, rise_nx, fall_nx;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (d),
    .q    (s)
  );

  // State and qualification counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: a candidate level must hold for STABLE_CYCLES en ticks; any reversal cancels it
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s) begin
          state_nx = WAIT_HI;
          cnt_nx   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nx = IDLE_LO;
          cnt_nx   = '0;
        end else if (en && cnt == CNT_LAST) begin
          state_nx = IDLE_HI;
          cnt_nx   = '0;
          q_nx     = 1'b1;
          rise_nx  = 1'b1;
        end else if (en) begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_nx = WAIT_LO;
          cnt_nx   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nx = IDLE_HI;
          cnt_nx   = '0;
        end else if (en && cnt == CNT_LAST) begin
          state_nx = IDLE_LO;
          cnt_nx   = '0;
          q_nx     = 1'b0;
          fall_nx  = 1'b1;
        end else if (en) begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE_LO;
        cnt_nx   = '0;
        q_nx     = 1'b0;
      end
    endcase
  end

  // Registered outputs; busy follows the state being entered so it lines up with state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      q    <= q_nx;
      rise <= rise_nx;
      fall <= fall_nx;
      busy <= (state_nx == WAIT_HI) || (state_nx == WAIT_LO);
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync
module tb_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;

  logic clock = 1'b0;
  logic reset;
  logic d;
  logic en;
  logic q, rise, fall, busy;

  int n_chk  = 0;
  int n_fail = 0;

  debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .d    (d),
    .en   (en),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: s is d delayed SYNC_STAGES clocks; a differing s becomes pending on
  // one edge and is accepted once STABLE_CYCLES further en ticks see it unchanged.
  bit sh [SYNC_STAGES];
  bit m_s, m_q, m_rise, m_fall, m_pend;
  int m_nen;

  // Behavioural reference updated on every clock edge and on reset
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      foreach (sh[i]) sh[i] = 1'b0;
      m_q = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_nen = 0;
    end else begin
      m_s = sh[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = d;
      m_rise = 0;
      m_fall = 0;
      if (m_s == m_q) begin
        m_pend = 0;
        m_nen  = 0;
      end else if (!m_pend) begin
        m_pend = 1;
        m_nen  = 0;
      end else if (en) begin
        m_nen++;
        if (m_nen == STABLE_CYCLES) begin
          m_q    = m_s;
          m_rise = m_s;
          m_fall = !m_s;
          m_pend = 0;
          m_nen  = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clock) begin
    #1;
    check("cyc_q", q, m_q);
    check("cyc_rise", rise, m_rise);
    check("cyc_fall", fall, m_fall);
    check("cyc_busy", busy, m_pend);
    if (m_pend) check("cyc_cnt", dut.cnt, m_nen);
  end

  // Drive d to val (releasing reset on the same edge) and check the 7-edge acceptance
  task automatic qual_run(input bit val);
    @(negedge clock);
    d     = val;
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      if (k < 7) check("qual_q_before", q, !val);
      if (k == 7) begin
        check("qual_q_edge7", q, val);
        check("qual_pulse_edge7", val ? rise : fall, 1);
        check("qual_other_pulse_edge7", val ? fall : rise, 0);
      end
      if (k == 8) check("qual_pulse_edge8", val ? rise : fall, 0);
    end
  endtask

  // Short excursion of d to val for len cycles; q must not move
  task automatic glitch(input bit val, input int len);
    int pulses;
    int busy_seen;
    int q_moves;
    pulses = 0; busy_seen = 0; q_moves = 0;
    @(negedge clock);
    d = val;
    for (int k = 0; k < 14; k++) begin
      if (k == len) begin
        @(negedge clock);
        d = !val;
      end
      @(posedge clock);
      #1;
      if (rise || fall) pulses++;
      if (busy) busy_seen = 1;
      if (q !== !val) q_moves++;
    end
    check("glitch_no_pulse", pulses, 0);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_q_held", q_moves, 0);
  endtask

  initial begin
    int en_ticks;
    bit prev_busy;
    bit rise_seen;
    reset = 1'b0;
    d     = 1'b1;
    en    = 1'b1;

    // 1: reset held with d=1
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("rst_q", q, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_busy", busy, 0);
    end

    // 2: clean rise
    qual_run(1'b1);

    // 3: 1->0->1 glitch while q=1
    glitch(1'b0, 3);

    // 5: clean fall
    qual_run(1'b0);

    // 3: 0->1->0 glitch while q=0
    glitch(1'b1, 3);

    // 4: en high every 4th cycle
    en_ticks  = 0;
    rise_seen = 0;
    prev_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      d  = 1'b1;
      en = (i % 4 == 0);
      prev_busy = busy;
      @(posedge clock);
      #1;
      if (prev_busy && en && !rise_seen) en_ticks++;
      if (rise && !rise_seen) begin
        rise_seen = 1;
        check("engate_ticks_at_rise", en_ticks, STABLE_CYCLES);
      end
    end
    check("engate_rise_seen", rise_seen, 1);
    check("engate_q", q, 1);
    @(negedge clock);
    en = 1'b1;

    // 6a: async reset with q=1
    #2 reset = 1'b0;
    #1;
    check("arst_q1_q", q, 0);
    check("arst_q1_fall", fall, 0);
    repeat (2) @(posedge clock);
    qual_run(1'b1);

    // 6b: async reset mid-WAIT_LO
    @(negedge clock);
    d = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("wlo_busy", busy, 1);
    check("wlo_q", q, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_wlo_q", q, 0);
    check("arst_wlo_fall", fall, 0);
    check("arst_wlo_busy", busy, 0);
    @(negedge clock);
    d = 1'b1;
    repeat (2) @(posedge clock);
    qual_run(1'b1);

    repeat (3) @(posedge clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
